// File: rtl/soc_multi_timer.sv
// soc_multi_timer: NUM_CH-channel Avalon-MM interval timer with per-channel prescaler,
// one-shot/continuous mode, snapshot register and a shared interrupt line.
module soc_multi_timer #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 32,
    parameter int RESET_PER = 49999,
    parameter int ADDR_W    = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);
    logic              wr;
    logic [ADDR_W-1:0] ch_a;
    logic [1:0]        reg_a;
    logic [NUM_CH-1:0] to, run, ito, cont, sel, tick;
    logic [7:0]        presc [NUM_CH];
    logic [7:0]        pre   [NUM_CH];
    logic [CNT_W-1:0]  period[NUM_CH];
    logic [CNT_W-1:0]  cnt   [NUM_CH];
    logic [CNT_W-1:0]  snap  [NUM_CH];
    logic [31:0]       rd;

    assign wr    = chipselect & ~write_n;
    assign ch_a  = address >> 2;
    assign reg_a = address[1:0];
    assign irq   = |(to & ito);

    always_comb begin
        sel  = '0;
        tick = '0;
        rd   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel[c]  = wr && ch_a == ADDR_W'(c);
            tick[c] = run[c] && pre[c] == presc[c];
            if (ch_a == ADDR_W'(c))
                rd = reg_a == 2'd0 ? {30'b0, run[c], to[c]} :
                     reg_a == 2'd1 ? {16'b0, presc[c], 6'b0, cont[c], ito[c]} :
                     reg_a == 2'd2 ? 32'(period[c]) : 32'(snap[c]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            to       <= '0;
            run      <= '0;
            ito      <= '0;
            cont     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                presc[c]  <= '0;
                pre[c]    <= '0;
                snap[c]   <= '0;
                period[c] <= CNT_W'(RESET_PER);
                cnt[c]    <= CNT_W'(RESET_PER);
            end
        end else begin
            readdata <= rd;
            for (int c = 0; c < NUM_CH; c++) begin
                if (run[c])
                    pre[c] <= tick[c] ? 8'd0 : pre[c] + 8'd1;
                if (tick[c]) begin
                    if (cnt[c] != '0)
                        cnt[c] <= cnt[c] - CNT_W'(1);
                    else begin
                        cnt[c] <= period[c];
                        to[c]  <= 1'b1;
                        if (!cont[c])
                            run[c] <= 1'b0;
                    end
                end
                if (sel[c]) begin
                    // a timeout on the same edge keeps TO set so the event is not lost
                    if (reg_a == 2'd0 && writedata[0] && !(tick[c] && cnt[c] == '0))
                        to[c] <= 1'b0;
                    if (reg_a == 2'd1) begin
                        ito[c]   <= writedata[0];
                        cont[c]  <= writedata[1];
                        presc[c] <= writedata[15:8];
                        if (writedata[2])
                            run[c] <= 1'b1;
                        else if (writedata[3])
                            run[c] <= 1'b0;
                    end
                    if (reg_a == 2'd2) begin
                        period[c] <= writedata[CNT_W-1:0];
                        cnt[c]    <= writedata[CNT_W-1:0];
                        pre[c]    <= '0;
                        run[c]    <= 1'b0;
                    end
                    if (reg_a == 2'd3)
                        snap[c] <= cnt[c];
                end
            end
        end
    end
endmodule
